// File: rtl/cpu_controller_pkg.sv
// cpu_controller_pkg: word widths, opcode and phase constants, and the strobe bundle shared by the controller.
package cpu_controller_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 5;
  localparam int OPCODE_WIDTH = DATA_WIDTH - ADDR_WIDTH;
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 3'd0;
  localparam logic [OPCODE_WIDTH-1:0] OP_SKZ = 3'd1;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 3'd2;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND = 3'd3;
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR = 3'd4;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = 3'd5;
  localparam logic [OPCODE_WIDTH-1:0] OP_STO = 3'd6;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 3'd7;
  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;
  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic ld_ac;
    logic ld_pc;
    logic inc_pc;
    logic wr;
    logic data_e;
    logic halt;
  } strobes_t;
endpackage

// File: rtl/cpu_controller_ctrl_decode.sv
// cpu_controller_ctrl_decode: pure table from (phase, opcode, zero) to the datapath strobes.
// Opcode terms are always ANDed with an execute-phase term, so fetch-phase garbage on opcode cannot leak.
module cpu_controller_ctrl_decode
  import cpu_controller_pkg::*;
(
  input  phase_e                  i_phase,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic                    i_zero,
  output strobes_t                o_strobes
);
  logic w_exec, w_late, w_aluop, w_hlt, w_skz, w_sto, w_jmp;
  assign w_exec  = i_phase[2];
  assign w_late  = i_phase == PH_ALU_OP || i_phase == PH_STORE;
  assign w_aluop = w_exec && (i_opcode == OP_ADD || i_opcode == OP_AND ||
                              i_opcode == OP_XOR || i_opcode == OP_LDA);
  assign w_hlt   = w_exec && i_opcode == OP_HLT;
  assign w_skz   = w_exec && i_opcode == OP_SKZ;
  assign w_sto   = w_exec && i_opcode == OP_STO;
  assign w_jmp   = w_exec && i_opcode == OP_JMP;
  assign o_strobes.sel    = !w_exec;
  assign o_strobes.rd     = (i_phase inside {PH_INST_FETCH, PH_INST_LOAD, PH_IDLE}) ||
                            (i_phase != PH_OP_ADDR && w_aluop);
  assign o_strobes.ld_ir  = i_phase == PH_INST_LOAD || i_phase == PH_IDLE;
  assign o_strobes.ld_ac  = i_phase == PH_STORE && w_aluop;
  assign o_strobes.ld_pc  = w_late && w_jmp;
  assign o_strobes.inc_pc = (i_phase == PH_OP_ADDR && w_exec && !w_hlt) ||
                            (i_phase == PH_ALU_OP && w_skz && i_zero);
  assign o_strobes.wr     = i_phase == PH_STORE && w_sto;
  assign o_strobes.data_e = w_late && w_sto;
  assign o_strobes.halt   = i_phase == PH_OP_ADDR && w_hlt;
endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: eight-phase instruction sequencer with a sticky halt latch.
// Outputs are combinational decodes of phase/opcode/zero, forced to halt-only once halted.
module cpu_controller
  import cpu_controller_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic                    i_zero,
  output logic                    o_sel,
  output logic                    o_rd,
  output logic                    o_ld_ir,
  output logic                    o_ld_ac,
  output logic                    o_ld_pc,
  output logic                    o_inc_pc,
  output logic                    o_wr,
  output logic                    o_data_e,
  output logic                    o_halt,
  output logic [2:0]              o_phase
);
  phase_e   r_phase;
  logic     r_halted;
  strobes_t w_dec, w_out;
  cpu_controller_ctrl_decode u_decode (
    .i_phase   (r_phase),
    .i_opcode  (i_opcode),
    .i_zero    (i_zero),
    .o_strobes (w_dec)
  );
  // The decoder's halt strobe doubles as the latch set and the counter freeze.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase  <= PH_INST_ADDR;
      r_halted <= 1'b0;
    end else if (!r_halted) begin
      if (w_dec.halt) r_halted <= 1'b1;
      else r_phase <= phase_e'(r_phase + 3'd1);
    end
  end
  assign w_out    = r_halted ? '{halt: 1'b1, default: 1'b0} : w_dec;
  assign o_sel    = w_out.sel;
  assign o_rd     = w_out.rd;
  assign o_ld_ir  = w_out.ld_ir;
  assign o_ld_ac  = w_out.ld_ac;
  assign o_ld_pc  = w_out.ld_pc;
  assign o_inc_pc = w_out.inc_pc;
  assign o_wr     = w_out.wr;
  assign o_data_e = w_out.data_e;
  assign o_halt   = w_out.halt;
  assign o_phase  = r_phase;
endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Eight-phase sequencer directly downstream of instruction_register; consumes its opcode field and generates every datapath strobe, including the ld_ir that loads the instruction register.
- One instruction executes per eight clocks: fetch in phases 0-3, execute in phases 4-7.
- Sits between instruction_register, program counter, memory, accumulator and ALU; the only stateful elements are the phase counter and the halt latch.

Parameters:
DATA_WIDTH, 8, instruction/data word width (matches `DATA_WIDTH)
ADDR_WIDTH, 5, operand/address field width (matches `ADDR_WIDTH)
OPCODE_WIDTH, DATA_WIDTH-ADDR_WIDTH (3), opcode field width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
opcode  in  OPCODE_WIDTH  from instruction_register opcode output
zero  in  1  accumulator-is-zero flag from ALU
sel  out  1  address mux select: 1 = PC, 0 = IR operand
rd  out  1  memory read enable
ld_ir  out  1  instruction register load
ld_ac  out  1  accumulator load
ld_pc  out  1  PC parallel load (jump)
inc_pc  out  1  PC increment
wr  out  1  memory write strobe
data_e  out  1  accumulator-to-bus tristate enable
halt  out  1  CPU halted, sticky
phase  out  3  current phase, for debug/verification

Behaviour:
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALUOP = ADD|AND|XOR|LDA.
- Phases: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
- Phase register: 3 bits, +1 per rising edge, wraps 7 -> 0.
- Registered state: phase and halted only. All outputs are combinational decodes of (phase, opcode, zero, halted); there is no output register.
- Decode table (any output not listed is 0):
  - Phase 0: sel.
  - Phase 1: sel, rd.
  - Phase 2: sel, rd, ld_ir.
  - Phase 3: sel, rd, ld_ir.
  - Phase 4: inc_pc when opcode != HLT; halt when opcode == HLT.
  - Phase 5: rd = ALUOP.
  - Phase 6: rd = ALUOP; inc_pc = SKZ & zero; ld_pc = JMP; data_e = STO.
  - Phase 7: rd = ALUOP; ld_ac = ALUOP; ld_pc = JMP; wr = STO; data_e = STO.
- IR timing: ld_ir is high across the edges ending phases 2 and 3, so opcode is stable from phase 3 onward. The controller samples opcode only in phases 4-7.
- Halt:
  - In phase 4 with opcode == HLT, the halted flag sets on the next edge and the phase counter freezes at 4.
  - While halted, only halt=1 is driven; all other outputs are 0, including inc_pc.
  - Only rst clears halted.
- Reset (asynchronous, any phase, including mid-execute):
  - phase = 0 and halted = 0 immediately, without waiting for a clock.
  - Outputs during reset: sel=1, all others 0, phase=0.
  - An interrupted STO must not assert wr after reset.
- After rst deasserts, the first rising edge advances to phase 1.
- X on opcode outside phases 4-7 must not propagate to any output.
- Mutual exclusion: wr and rd are never high together; ld_pc and inc_pc are never high together in the same phase (SKZ and JMP are distinct opcodes).

Decomposition:
- Shared package/include (cpu_defines alongside `DATA_WIDTH/`ADDR_WIDTH) holds:
  - opcode constants OP_HLT..OP_JMP;
  - phase constants PH_INST_ADDR..PH_STORE.
- One sub-module is natural: ctrl_decode, a pure combinational table mapping (phase, opcode, zero) to the strobe vector.
- The top level keeps the phase counter and halt latch, and applies halt gating to the decoder outputs.

Test Plan:
- Reset held 3 cycles, then released -> phase=0, sel=1, all other strobes 0; after 8 clocks phase back at 0.
- opcode=LDA (5), zero=0, one full instruction -> ld_ir high in phases 2-3, rd high in phases 1,2,3,5,6,7, ld_ac high only in phase 7, wr never high.
- opcode=STO (6) -> data_e high in phases 6-7, wr high only in phase 7, rd low in phases 5-7.
- opcode=SKZ (1): first with zero=1, then with zero=0 -> with zero=1, inc_pc high in phases 4 and 6; with zero=0, inc_pc high in phase 4 only.
- opcode=JMP (7) -> ld_pc high in phases 6 and 7, inc_pc high in phase 4 only.
- opcode=HLT (0) -> halt=1 in phase 4, phase stays 4 for 20 clocks with all other outputs 0; then rst asserted mid-cycle -> halt=0 and phase=0 immediately.
